// File: rtl/preg_free_manager_pkg.sv
// preg_free_manager_pkg: sizes and pointer/preg types shared by the free-list manager.
package preg_free_manager_pkg;
    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 16;
    localparam int MAX_PREDICT_DEPTH = 4;
    localparam int MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH);
    localparam int PB = $clog2(NUM_PREGS);
    typedef logic [PB-1:0] preg_t;
    typedef logic [PB:0] ptr_t;
endpackage

// File: rtl/preg_ckpt_table.sv
// preg_ckpt_table: per-branch snapshot of the allocation head, one write port and one async read.
module preg_ckpt_table
    import preg_free_manager_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              we,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] wtag,
    input  logic [PB:0]                       wdata,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] rtag,
    output logic [PB:0]                       rdata
);
    ptr_t slots [MAX_PREDICT_DEPTH];

    always_ff @(posedge clk) begin
        if (reset)
            for (int i = 0; i < MAX_PREDICT_DEPTH; i++) slots[i] <= '0;
        else if (we)
            slots[wtag] <= wdata;
    end

    assign rdata = slots[rtag];
endmodule

// File: rtl/preg_free_manager.sv
// preg_free_manager: circular physical-register free list, 2 allocs + 2 releases per cycle,
// with branch checkpoints of the allocation head.
module preg_free_manager
    import preg_free_manager_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [1:0]                        alloc_cnt,
    output logic                              alloc_ok,
    output logic [PB-1:0]                     alloc_preg0,
    output logic [PB-1:0]                     alloc_preg1,
    output logic [PB:0]                       num_free,
    input  logic                              ckpt_valid,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] ckpt_tag,
    input  logic [1:0]                        release_cnt,
    input  logic [PB-1:0]                     release_preg0,
    input  logic [PB-1:0]                     release_preg1,
    input  logic                              branch_shootdown,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] shootdown_branch_tag
);
    localparam logic [PB+1:0] LIST_DEPTH = NUM_PREGS[PB+1:0];

    preg_t list [NUM_PREGS];
    ptr_t head, tail, head_next, tail_next, head_p1, tail_p1, ckpt_head;
    logic [PB+1:0] rel_sum;
    logic rel_ok;

    always_comb begin
        num_free = tail - head;
        head_p1 = head + ptr_t'(1);
        tail_p1 = tail + ptr_t'(1);
        alloc_ok = num_free >= ptr_t'(alloc_cnt) && !branch_shootdown;
        alloc_preg0 = list[head[PB-1:0]];
        alloc_preg1 = list[head_p1[PB-1:0]];
        rel_sum = {1'b0, num_free} + {{PB{1'b0}}, release_cnt};
        rel_ok = rel_sum <= LIST_DEPTH;
        head_next = branch_shootdown ? ckpt_head : alloc_ok ? head + ptr_t'(alloc_cnt) : head;
        tail_next = rel_ok ? tail + ptr_t'(release_cnt) : tail;
    end

    // The snapshot is the post-allocate head so a branch's own same-cycle allocation survives rollback.
    preg_ckpt_table u_ckpt (
        .clk   (clk),
        .reset (reset),
        .we    (ckpt_valid && !branch_shootdown),
        .wtag  (ckpt_tag),
        .wdata (head_next),
        .rtag  (shootdown_branch_tag),
        .rdata (ckpt_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= ptr_t'(NUM_PREGS - NUM_AREGS);
            for (int i = 0; i < NUM_PREGS; i++) list[i] <= preg_t'(NUM_AREGS + i);
        end else begin
            head <= head_next;
            tail <= tail_next;
            if (rel_ok && release_cnt != 2'd0) list[tail[PB-1:0]] <= release_preg0;
            if (rel_ok && release_cnt == 2'd2) list[tail_p1[PB-1:0]] <= release_preg1;
        end
    end

    a_release_overflow: assert property (@(posedge clk) disable iff (reset) rel_ok);
    a_cnt_legal: assert property (@(posedge clk) disable iff (reset) alloc_cnt != 2'd3 && release_cnt != 2'd3);
    // Retire only frees committed pregs, so the tail can never overrun a restored head.
    a_restore_behind_tail: assert property (@(posedge clk) disable iff (reset)
        branch_shootdown |-> ptr_t'(tail_next - ckpt_head) <= ptr_t'(NUM_PREGS));
endmodule

// File: tb/tb_preg_free_manager.sv
// tb_preg_free_manager: scoreboard of expected allocation order, checkpoint rollback and duplicate tracking.
module tb_preg_free_manager;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] alloc_cnt, release_cnt, ckpt_tag, shootdown_branch_tag;
    logic       alloc_ok, ckpt_valid, branch_shootdown;
    logic [5:0] alloc_preg0, alloc_preg1, release_preg0, release_preg1;
    logic [6:0] num_free;

    int sb[$];
    int alog[$];
    int ckpt_pos[4];
    bit busy[64];
    int total = 0;
    int passed = 0;

    preg_free_manager dut (
        .clk                  (clk),
        .reset                (reset),
        .alloc_cnt            (alloc_cnt),
        .alloc_ok             (alloc_ok),
        .alloc_preg0          (alloc_preg0),
        .alloc_preg1          (alloc_preg1),
        .num_free             (num_free),
        .ckpt_valid           (ckpt_valid),
        .ckpt_tag             (ckpt_tag),
        .release_cnt          (release_cnt),
        .release_preg0        (release_preg0),
        .release_preg1        (release_preg1),
        .branch_shootdown     (branch_shootdown),
        .shootdown_branch_tag (shootdown_branch_tag)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        sb.delete();
        alog.delete();
        for (int i = 16; i < 64; i++) sb.push_back(i);
        for (int i = 0; i < 4; i++) ckpt_pos[i] = 0;
        for (int i = 0; i < 64; i++) busy[i] = (i < 16);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        alloc_cnt = 2'd2;
        release_cnt = 2'd2;
        release_preg0 = 6'd1;
        release_preg1 = 6'd2;
        ckpt_valid = 1'b1;
        ckpt_tag = 2'd1;
        branch_shootdown = 1'b1;
        shootdown_branch_tag = 2'd1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        alloc_cnt = 2'd0;
        release_cnt = 2'd0;
        release_preg0 = 6'd0;
        release_preg1 = 6'd0;
        ckpt_valid = 1'b0;
        ckpt_tag = 2'd0;
        branch_shootdown = 1'b0;
        shootdown_branch_tag = 2'd0;
        model_reset();
        #1;
    endtask

    // One cycle: drive at negedge, compare against the scoreboard, update it, advance past posedge.
    task automatic step(input int ac, input int rc = 0, input int r0 = 0, input int r1 = 0,
                        input bit ck = 1'b0, input int ct = 0, input bit sd = 1'b0, input int st = 0);
        bit ok;
        int p;
        @(negedge clk);
        alloc_cnt = 2'(ac);
        release_cnt = 2'(rc);
        release_preg0 = 6'(r0);
        release_preg1 = 6'(r1);
        ckpt_valid = ck;
        ckpt_tag = 2'(ct);
        branch_shootdown = sd;
        shootdown_branch_tag = 2'(st);
        #1;
        ok = (sb.size() >= ac) && !sd;
        total++;
        if (num_free === 7'(sb.size())) passed++;
        else $display("FAIL num_free: got %0d expected %0d", num_free, sb.size());
        total++;
        if (alloc_ok === ok) passed++;
        else $display("FAIL alloc_ok: got %b expected %b (cnt=%0d sd=%b)", alloc_ok, ok, ac, sd);
        if (sd) begin
            while (alog.size() > ckpt_pos[st]) begin
                p = alog.pop_back();
                busy[p] = 1'b0;
                sb.push_front(p);
            end
        end else if (ok) begin
            for (int i = 0; i < ac; i++) begin
                p = sb.pop_front();
                total++;
                if ((i == 0 ? alloc_preg0 : alloc_preg1) === 6'(p)) passed++;
                else $display("FAIL alloc_preg%0d: got %0d expected %0d", i, (i == 0 ? alloc_preg0 : alloc_preg1), p);
                total++;
                if (!busy[p]) passed++;
                else $display("FAIL dup: preg %0d handed out while still in use", p);
                busy[p] = 1'b1;
                alog.push_back(p);
            end
        end
        if (rc > 0) begin
            sb.push_back(r0);
            busy[r0] = 1'b0;
        end
        if (rc > 1) begin
            sb.push_back(r1);
            busy[r1] = 1'b0;
        end
        if (ck && !sd) ckpt_pos[ct] = alog.size();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (num_free === 7'd48) passed++;
        else $display("FAIL reset_num_free: got %0d expected 48", num_free);
        total++;
        if (alloc_preg0 === 6'd16 && alloc_preg1 === 6'd17) passed++;
        else $display("FAIL reset_pregs: got %0d,%0d expected 16,17", alloc_preg0, alloc_preg1);
        step(2);
        total++;
        if (alloc_preg0 === 6'd18 && num_free === 7'd46) passed++;
        else $display("FAIL first_alloc: got preg0=%0d free=%0d expected 18,46", alloc_preg0, num_free);
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 24; i++) step(2);
        total++;
        if (num_free === 7'd0) passed++;
        else $display("FAIL drain_empty: got %0d expected 0", num_free);
        step(1);
        step(0);
        total++;
        if (num_free === 7'd0) passed++;
        else $display("FAIL stall_head: got %0d expected 0", num_free);
    endtask

    task automatic test_release_from_empty();
        step(0, 2, 20, 33);
        total++;
        if (num_free === 7'd2 && alloc_preg0 === 6'd20 && alloc_preg1 === 6'd33) passed++;
        else $display("FAIL release_empty: got free=%0d pregs=%0d,%0d expected 2,20,33", num_free, alloc_preg0, alloc_preg1);
        step(2);
    endtask

    task automatic test_checkpoint();
        do_reset();
        step(2, 0, 0, 0, 1'b1, 1);
        for (int i = 0; i < 3; i++) step(2);
        step(0, 0, 0, 0, 1'b0, 0, 1'b1, 1);
        total++;
        if (num_free === 7'd46 && alloc_preg0 === 6'd18) passed++;
        else $display("FAIL ckpt_restore: got free=%0d preg0=%0d expected 46,18", num_free, alloc_preg0);
    endtask

    task automatic test_shootdown_same_cycle();
        step(2);
        step(2);
        step(2, 1, 5, 0, 1'b1, 3, 1'b1, 1);
        total++;
        if (num_free === 7'd47 && alloc_preg0 === 6'd18) passed++;
        else $display("FAIL sd_same_cycle: got free=%0d preg0=%0d expected 47,18", num_free, alloc_preg0);
        step(0, 0, 0, 0, 1'b0, 0, 1'b1, 3);
        total++;
        if (num_free === 7'd49 && alloc_preg0 === 6'd16) passed++;
        else $display("FAIL sd_ckpt_ignored: got free=%0d preg0=%0d expected 49,16", num_free, alloc_preg0);
    endtask

    task automatic test_back_to_back();
        int rq[$];
        int r0, r1;
        do_reset();
        for (int i = 0; i < 16; i++) rq.push_back(i);
        for (int c = 0; c < 200; c++) begin
            r0 = rq.pop_front();
            r1 = rq.pop_front();
            step(2, 2, r0, r1);
            rq.push_back(alog[alog.size()-2]);
            rq.push_back(alog[alog.size()-1]);
        end
        total++;
        if (num_free === 7'd48) passed++;
        else $display("FAIL steady_free: got %0d expected 48", num_free);
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_drain();
        test_release_from_empty();
        test_checkpoint();
        test_shootdown_same_cycle();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
